// File: rtl/decoder_nx_scan.sv
// Registered N-to-2^N one-hot decoder with direct (valid/ready) and scan modes.
// Define DECODER_SCAN_BLANK_EN to insert one blank cycle after each scan step.
module decoder_nx_scan #(
    parameter int IN_W  = 3,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in,
    output logic [2**IN_W-1:0]   out,
    output logic [IN_W-1:0]      idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**IN_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [IN_W-1:0]  IDX_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IN_W-1:0]  idx_n;
    logic [OUT_W-1:0] out_n;
    logic             wrap_n;
    logic             held, held_n;
    logic             blank, blank_n;
    logic             hs;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] i);
        logic [OUT_W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    assign in_ready = ~rst & en & ~mode;
    assign hs       = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            out   <= '0;
            wrap  <= 1'b0;
            held  <= 1'b0;
            blank <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            out   <= out_n;
            wrap  <= wrap_n;
            held  <= held_n;
            blank <= blank_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        out_n   = out;
        wrap_n  = 1'b0;
        held_n  = held;
        blank_n = blank;
        if (!en) begin
            // Freeze everything except the select lines, which go dark.
            out_n  = '0;
            held_n = 1'b1;
        end else if (mode) begin
            held_n = 1'b0;
            if (state != SCAN) begin
                state_n = SCAN;
                idx_n   = '0;
                cnt_n   = '0;
                out_n   = onehot('0);
                blank_n = 1'b0;
            end else if (held) begin
                // Resume cycle re-lights the frozen index without counting.
                out_n = blank ? '0 : onehot(idx);
`ifdef DECODER_SCAN_BLANK_EN
            end else if (blank) begin
                blank_n = 1'b0;
                out_n   = onehot(idx);
`endif
            end else if (cnt == CNT_MAX) begin
                cnt_n  = '0;
                idx_n  = idx + 1'b1;
                wrap_n = (idx == IDX_MAX);
`ifdef DECODER_SCAN_BLANK_EN
                out_n   = '0;
                blank_n = 1'b1;
`else
                out_n   = onehot(idx + 1'b1);
`endif
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else begin
            state_n = DIRECT;
            held_n  = 1'b0;
            blank_n = 1'b0;
            if (hs) begin
                idx_n = in;
                out_n = onehot(in);
            end else if (held && state != IDLE) begin
                out_n = onehot(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot0(out));
    end

endmodule

// File: tb/tb_decoder_nx_scan.sv
// Scoreboard bench for decoder_nx_scan: an IN_W=3/DWELL=4 instance and
// an IN_W=2/DWELL=1 instance, both checked against a cycle-count model.
module tb_decoder_nx_scan;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, mode = 1'b0, in_valid = 1'b0;
    logic [2:0] in = '0;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap, in_ready;

    logic       rst2 = 1'b1, en2 = 1'b0, mode2 = 1'b0, in_valid2 = 1'b0;
    logic [1:0] in2 = '0;
    logic [3:0] out2;
    logic [1:0] idx2;
    logic       wrap2, in_ready2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] o;
        logic [2:0] i;
        logic       w;
        logic       r;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    decoder_nx_scan #(.IN_W(3), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out(out), .idx(idx), .wrap(wrap)
    );

    decoder_nx_scan #(.IN_W(2), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in(in2),
        .out(out2), .idx(idx2), .wrap(wrap2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected scan output k cycles after the scan-entry edge.
    function automatic void model(input int k, input int in_w,
                                  input int dwell, output int o,
                                  output int i, output bit w);
        int m, per, st, pos;
        if (k < dwell) begin
            i = 0;
            w = 1'b0;
            o = 1;
        end else begin
            m   = k - dwell;
            per = dwell + B;
            st  = m / per + 1;
            pos = m % per;
            i   = st % (1 << in_w);
            w   = (pos == 0) && (i == 0);
            o   = (B == 1 && pos == 0) ? 0 : (1 << i);
        end
    endfunction

    task automatic enter_scan;
        mode = 1'b0;
        in_valid = 1'b0;
        tick;
        mode = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            q.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
            tick;
            e = q.pop_front();
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL reset: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
        checks++;
        if ({out2, idx2, wrap2, in_ready2} !== 8'h00) begin
            errors++;
            $display("FAIL reset2: out=%h idx=%0d wrap=%b rdy=%b want 0 0 0 0",
                     out2, idx2, wrap2, in_ready2);
        end
    endtask

    task automatic test_direct;
        rst = 1'b0;
        en = 1'b1;
        mode = 1'b0;
        in = 3'd5;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_comb: rdy=%b want 1", in_ready);
        end
        for (int c = 0; c < 11; c++) begin
            q.push_back('{8'h20, 3'd5, 1'b0, 1'b1});
            tick;
            in_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL direct c%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         c, out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] v;
        logic [2:0] vals [3] = '{3'd0, 3'd7, 3'd3};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                v = vals[c];
                in = v;
                in_valid = 1'b1;
                q.push_back('{8'h01 << v, v, 1'b0, 1'b1});
            end else if (c == 3) begin
                en = 1'b0;
                in = 3'd6;
                in_valid = 1'b1;
                q.push_back('{8'h00, 3'd3, 1'b0, 1'b0});
            end else begin
                en = 1'b1;
                in_valid = 1'b0;
                q.push_back('{8'h08, 3'd3, 1'b0, 1'b1});
            end
            tick;
            e = q.pop_front();
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL b2b c%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         c, out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_scan_sweep;
        int o, i, period, wraps;
        bit w;
        period = (4 + B) * 8;
        wraps = 0;
        mode = 1'b1;
        in = 3'd7;
        in_valid = 1'b1;
        for (int k = 0; k <= period; k++) begin
            model(k, 3, 4, o, i, w);
            q.push_back('{8'(o), 3'(i), w, 1'b0});
            tick;
            e = q.pop_front();
            wraps += int'(wrap);
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL scan k%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         k, out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (wraps !== 1) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_enable_freeze;
        int o, i, kf;
        bit w;
        kf = (B == 1) ? 11 : 9;
        enter_scan;
        for (int k = 1; k <= kf + 12; k++) begin
            if (k <= kf) begin
                model(k, 3, 4, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end else if (k <= kf + 5) begin
                en = 1'b0;
                q.push_back('{8'h00, 3'd2, 1'b0, 1'b0});
            end else begin
                en = 1'b1;
                model(k - 6, 3, 4, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end
            tick;
            e = q.pop_front();
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL freeze k%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         k, out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
    endtask

    task automatic test_mode_switch;
        int o, i, k6;
        bit w;
        k6 = (B == 1) ? 30 : 24;
        enter_scan;
        for (int k = 1; k <= k6 + 4; k++) begin
            if (k <= k6) begin
                model(k, 3, 4, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end else if (k == k6 + 1) begin
                mode = 1'b0;
                in_valid = 1'b0;
                q.push_back('{8'h40, 3'd6, 1'b0, 1'b1});
            end else if (k == k6 + 2) begin
                in = 3'd1;
                in_valid = 1'b1;
                q.push_back('{8'h02, 3'd1, 1'b0, 1'b1});
            end else if (k == k6 + 3) begin
                mode = 1'b1;
                in = 3'd7;
                q.push_back('{8'h01, 3'd0, 1'b0, 1'b0});
            end else begin
                in_valid = 1'b0;
                model(1, 3, 4, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end
            tick;
            e = q.pop_front();
            checks++;
            if ({out, idx, wrap, in_ready} !== {e.o, e.i, e.w, e.r}) begin
                errors++;
                $display("FAIL mode k%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         k, out, idx, wrap, in_ready, e.o, e.i, e.w, e.r);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        int o, i, k3, n;
        bit w;
        k3 = (B == 1) ? 6 : 3;
        n = 4 * (1 + B);
        rst2 = 1'b0;
        en2 = 1'b1;
        mode2 = 1'b1;
        for (int k = 0; k <= k3 + 1 + n + 1; k++) begin
            if (k <= k3) begin
                model(k, 2, 1, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end else if (k == k3 + 1) begin
                rst2 = 1'b1;
                q.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
            end else begin
                rst2 = 1'b0;
                model(k - k3 - 2, 2, 1, o, i, w);
                q.push_back('{8'(o), 3'(i), w, 1'b0});
            end
            tick;
            e = q.pop_front();
            checks++;
            if ({out2, idx2, wrap2, in_ready2} !==
                {e.o[3:0], e.i[1:0], e.w, e.r}) begin
                errors++;
                $display("FAIL rst_mid k%0d: out=%h idx=%0d wrap=%b rdy=%b want %h %0d %b %b",
                         k, out2, idx2, wrap2, in_ready2,
                         e.o[3:0], e.i[1:0], e.w, e.r);
            end
        end
    endtask

    initial begin
        test_reset;
        test_direct;
        test_back_to_back;
        test_scan_sweep;
        test_enable_freeze;
        test_mode_switch;
        test_reset_mid_scan;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
